// File: rtl/delay_pkg.sv
// Shared encodings and width helpers for the delay buffer pool arbiter.
package delay_pkg;

   typedef logic [1:0] dly_op_t;

   localparam dly_op_t DLY_OP_READ  = 2'b00;
   localparam dly_op_t DLY_OP_WRITE = 2'b01;
   localparam dly_op_t DLY_OP_ALLOC = 2'b10;
   localparam dly_op_t DLY_OP_FREE  = 2'b11;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_DECODE    = 2'd1;
   localparam logic [1:0] ST_SRAM_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP      = 2'd3;

   // Index width for n entries, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; pointer moves past the winner on adv.
module rr_arbiter
   import delay_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr;
   logic [IW:0]   sum;
   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (IW+1)'(i);
         if (sum >= (IW+1)'(N))
            sum = sum - (IW+1)'(N);
         idx = sum[IW-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (adv)
         ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
   end

endmodule

// File: rtl/delay_pool_arbiter.sv
// Pool of power-of-two circular delay buffers in one SRAM,
// shared round-robin by several clients over a single SRAM port.
module delay_pool_arbiter
   import delay_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int N_CLIENTS  = 4,
   parameter int N_BUFS     = 32,
   parameter int ADDR_W     = 12,
   parameter int SRAM_WORDS = 4096
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_CLIENTS-1:0]          cl_valid,
   input  logic [2*N_CLIENTS-1:0]        cl_op,
   input  logic [DATA_W*N_CLIENTS-1:0]   cl_handle,
   input  logic [DATA_W*N_CLIENTS-1:0]   cl_arg,
   output logic [N_CLIENTS-1:0]          cl_ready,
   output logic [N_CLIENTS-1:0]          rsp_valid,
   output logic [DATA_W-1:0]             rsp_data,
   output logic                          rsp_err,
   output logic                          sram_req,
   output logic                          sram_we,
   output logic [ADDR_W-1:0]             sram_addr,
   output logic [DATA_W-1:0]             sram_wdata,
   input  logic                          sram_ack,
   input  logic [DATA_W-1:0]             sram_rdata,
   input  logic                          sram_err
);

   localparam int HW = idx_w(N_BUFS);
   localparam int IW = idx_w(N_CLIENTS);
   localparam int SW = ADDR_W + 1;
   localparam int CW = 32;

   logic [1:0]        state;
   dly_op_t           op_q;
   logic [DATA_W-1:0] handle_q;
   logic [DATA_W-1:0] arg_q;
   logic [IW-1:0]     id_q;
   logic [SW-1:0]     alloc_ptr;
   logic [HW:0]       next_handle;

   logic [ADDR_W-1:0] base_mem [N_BUFS];
   logic [SW-1:0]     size_mem [N_BUFS];
   logic [ADDR_W-1:0] pos_mem  [N_BUFS];

   logic [N_CLIENTS-1:0] grant;
   logic [IW-1:0]        grant_idx;
   logic                 accept;

   dly_op_t           sel_op;
   logic [DATA_W-1:0] sel_handle;
   logic [DATA_W-1:0] sel_arg;

   logic [HW-1:0]     hidx;
   logic [HW-1:0]     nh_idx;
   logic              handle_ok;
   logic [ADDR_W-1:0] t_base;
   logic [SW-1:0]     t_size;
   logic [ADDR_W-1:0] t_pos;
   logic [ADDR_W-1:0] mask;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] pos_next;
   logic              d_ok;
   logic              pow2;
   logic              fits;
   logic              room;
   logic              alloc_ok;

   assign accept   = (state == ST_IDLE) && !reset && (|cl_valid);
   assign cl_ready = accept ? grant : '0;

   rr_arbiter #(
      .N  (N_CLIENTS),
      .IW (IW)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (cl_valid),
      .adv       (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_op     = DLY_OP_READ;
      sel_handle = '0;
      sel_arg    = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (grant_idx == IW'(i)) begin
            sel_op     = cl_op[2*i +: 2];
            sel_handle = cl_handle[DATA_W*i +: DATA_W];
            sel_arg    = cl_arg[DATA_W*i +: DATA_W];
         end
      end
   end

   assign hidx      = handle_q[HW-1:0];
   assign nh_idx    = next_handle[HW-1:0];
   assign handle_ok = ((handle_q >> HW) == '0) && ({1'b0, hidx} < next_handle);

   assign t_base = base_mem[hidx];
   assign t_size = size_mem[hidx];
   assign t_pos  = pos_mem[hidx];
   assign mask   = ADDR_W'(t_size - SW'(1));

   // pos is the next slot to be written, so delay 0 sits one behind it.
   assign rd_addr  = t_base + ((t_pos - ADDR_W'(1) - ADDR_W'(arg_q)) & mask);
   assign wr_addr  = t_base + t_pos;
   assign pos_next = (t_pos + ADDR_W'(1)) & mask;

   assign d_ok     = CW'(arg_q) < CW'(t_size);
   assign pow2     = (arg_q != '0) && ((arg_q & (arg_q - DATA_W'(1))) == '0);
   assign fits     = (CW'(alloc_ptr) + CW'(arg_q)) <= CW'(SRAM_WORDS);
   assign room     = CW'(next_handle) < CW'(N_BUFS);
   assign alloc_ok = pow2 && fits && room;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_q        <= DLY_OP_READ;
         handle_q    <= '0;
         arg_q       <= '0;
         id_q        <= '0;
         alloc_ptr   <= '0;
         next_handle <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         sram_req    <= 1'b0;
         sram_we     <= 1'b0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
      end else begin
         rsp_valid <= '0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q     <= sel_op;
                  handle_q <= sel_handle;
                  arg_q    <= sel_arg;
                  id_q     <= grant_idx;
                  state    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               unique case (op_q)
                  DLY_OP_READ, DLY_OP_WRITE: begin
                     if (!handle_ok || (op_q == DLY_OP_READ && !d_ok)) begin
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= N_CLIENTS'(1) << id_q;
                        state     <= ST_RESP;
                     end else begin
                        sram_req   <= 1'b1;
                        sram_we    <= (op_q == DLY_OP_WRITE);
                        sram_addr  <= (op_q == DLY_OP_WRITE) ? wr_addr : rd_addr;
                        sram_wdata <= (op_q == DLY_OP_WRITE) ? arg_q : '0;
                        state      <= ST_SRAM_WAIT;
                     end
                  end
                  DLY_OP_ALLOC: begin
                     if (alloc_ok) begin
                        rsp_err     <= 1'b0;
                        rsp_data    <= DATA_W'(next_handle);
                        alloc_ptr   <= alloc_ptr + SW'(arg_q);
                        next_handle <= next_handle + (HW+1)'(1);
                     end else begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                     end
                     rsp_valid <= N_CLIENTS'(1) << id_q;
                     state     <= ST_RESP;
                  end
                  DLY_OP_FREE: begin
                     next_handle <= '0;
                     alloc_ptr   <= '0;
                     rsp_err     <= 1'b0;
                     rsp_data    <= '0;
                     rsp_valid   <= N_CLIENTS'(1) << id_q;
                     state       <= ST_RESP;
                  end
               endcase
            end
            ST_SRAM_WAIT: begin
               if (sram_ack || sram_err) begin
                  sram_req  <= 1'b0;
                  sram_we   <= 1'b0;
                  rsp_err   <= sram_err;
                  rsp_data  <= (sram_err || sram_we) ? '0 : sram_rdata;
                  rsp_valid <= N_CLIENTS'(1) << id_q;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               rsp_data <= '0;
               rsp_err  <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Buffer table survives reset; next_handle alone decides validity.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_DECODE && op_q == DLY_OP_ALLOC && alloc_ok) begin
            base_mem[nh_idx] <= alloc_ptr[ADDR_W-1:0];
            size_mem[nh_idx] <= SW'(arg_q);
            pos_mem[nh_idx]  <= '0;
         end
         if (state == ST_SRAM_WAIT && sram_we && sram_ack && !sram_err)
            pos_mem[hidx] <= pos_next;
      end
   end

endmodule

// File: tb/tb_delay_pool_arbiter.sv
// Directed bench for delay_pool_arbiter with a behavioural SRAM.
module tb_delay_pool_arbiter;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int NB = 32;
   localparam int AW = 12;
   localparam int SWORDS = 4096;

   localparam logic [1:0] RD = 2'b00;
   localparam logic [1:0] WR = 2'b01;
   localparam logic [1:0] AL = 2'b10;
   localparam logic [1:0] FR = 2'b11;

   logic clk = 1'b0;
   logic reset;
   logic [NC-1:0]    cl_valid;
   logic [2*NC-1:0]  cl_op;
   logic [DW*NC-1:0] cl_handle;
   logic [DW*NC-1:0] cl_arg;
   logic [NC-1:0]    cl_ready;
   logic [NC-1:0]    rsp_valid;
   logic [DW-1:0]    rsp_data;
   logic             rsp_err;
   logic             sram_req;
   logic             sram_we;
   logic [AW-1:0]    sram_addr;
   logic [DW-1:0]    sram_wdata;
   logic             sram_ack = 1'b0;
   logic [DW-1:0]    sram_rdata = '0;
   logic             sram_err = 1'b0;

   always #5 clk = ~clk;

   delay_pool_arbiter #(
      .DATA_W(DW), .N_CLIENTS(NC), .N_BUFS(NB), .ADDR_W(AW), .SRAM_WORDS(SWORDS)
   ) dut (
      .clk(clk), .reset(reset),
      .cl_valid(cl_valid), .cl_op(cl_op), .cl_handle(cl_handle), .cl_arg(cl_arg),
      .cl_ready(cl_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_ack(sram_ack), .sram_rdata(sram_rdata),
      .sram_err(sram_err)
   );

   // SRAM model: answers sram_lat negedges after seeing a request.
   logic [DW-1:0] mem [SWORDS];
   int            sram_lat = 0;
   bit            inject_err = 1'b0;
   int            wcnt = 0;
   logic [AW-1:0] last_addr = '0;

   always @(negedge clk) begin
      if (sram_ack || sram_err) begin
         sram_ack = 1'b0;
         sram_err = 1'b0;
         wcnt = 0;
      end else if (sram_req) begin
         if (wcnt >= sram_lat) begin
            last_addr = sram_addr;
            if (inject_err)
               sram_err = 1'b1;
            else begin
               sram_ack = 1'b1;
               if (sram_we) mem[sram_addr] = sram_wdata;
               else sram_rdata = mem[sram_addr];
            end
            wcnt = 0;
         end else
            wcnt++;
      end else
         wcnt = 0;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         c;
      logic [1:0] op;
      logic [15:0] h;
      logic [15:0] a;
      bit         e;
      bit         cd;
      logic [15:0] d;
      bit         ca;
      logic [11:0] addr;
      string      name;
   } vec_t;

   vec_t v[$];

   function automatic void add(input int c, input logic [1:0] op, input logic [15:0] h,
                               input logic [15:0] a, input bit e, input bit cd,
                               input logic [15:0] d, input bit ca, input logic [11:0] addr,
                               input string name);
      vec_t x;
      x.c = c; x.op = op; x.h = h; x.a = a; x.e = e;
      x.cd = cd; x.d = d; x.ca = ca; x.addr = addr; x.name = name;
      v.push_back(x);
   endfunction

   task automatic launch(input int c, input logic [1:0] op, input logic [15:0] h,
                         input logic [15:0] a, output bit ok);
      @(negedge clk);
      cl_valid[c] = 1'b1;
      cl_op[2*c +: 2] = op;
      cl_handle[DW*c +: DW] = h;
      cl_arg[DW*c +: DW] = a;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         if (cl_ready[c]) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         @(negedge clk);
      end
      cl_valid[c] = 1'b0;
   endtask

   task automatic await_rsp(input int c, output bit got, output logic [15:0] d,
                            output bit e, output int lat);
      got = 1'b0; d = '0; e = 1'b0; lat = 1;
      for (int i = 0; i < 60 && !got; i++) begin
         if (rsp_valid[c]) begin
            got = 1'b1;
            d = rsp_data;
            e = rsp_err;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
   endtask

   task automatic do_req(input int c, input logic [1:0] op, input logic [15:0] h,
                         input logic [15:0] a, output logic [15:0] d, output bit e,
                         output int lat, output bit got);
      bit ok;
      launch(c, op, h, a, ok);
      check("accept", ok, 1);
      got = 1'b0; d = '0; e = 1'b0; lat = 0;
      if (ok) begin
         await_rsp(c, got, d, e, lat);
         check("rsp_seen", got, 1);
      end
   endtask

   task automatic run_vecs();
      logic [15:0] d;
      bit e;
      int lat;
      bit got;
      foreach (v[i]) begin
         do_req(v[i].c, v[i].op, v[i].h, v[i].a, d, e, lat, got);
         if (got) begin
            check({v[i].name, "_err"}, e, v[i].e);
            if (v[i].cd) check({v[i].name, "_data"}, d, v[i].d);
            if (v[i].ca) check({v[i].name, "_addr"}, last_addr, v[i].addr);
            check({v[i].name, "_lat"}, lat, (v[i].op[1] == 1'b0 && !v[i].e) ? 3 : 2);
         end
      end
      v.delete();
   endtask

   int          order[5];
   int          seen;
   int          hits;
   bit          ok;
   bit          req_seen;
   logic [15:0] d;
   bit          e;
   int          lat;
   bit          got;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      cl_valid = '0; cl_op = '0; cl_handle = '0; cl_arg = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sram_req", sram_req, 0);
      check("rst_sram_we", sram_we, 0);
      check("rst_sram_addr", sram_addr, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_cl_ready", cl_ready, 0);
      reset = 1'b0;

      // All clients contend with harmless free-all requests.
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
         cl_valid[c] = 1'b1;
         cl_op[2*c +: 2] = FR;
         cl_handle[DW*c +: DW] = '0;
         cl_arg[DW*c +: DW] = '0;
      end
      seen = 0;
      for (int i = 0; i < 100 && seen < 5; i++) begin
         #1;
         if (cl_ready != '0) begin
            check("rr_onehot", 32'($onehot(cl_ready)), 1);
            for (int c = 0; c < NC; c++) if (cl_ready[c]) order[seen] = c;
            seen++;
         end
         @(negedge clk);
      end
      cl_valid = '0;
      check("rr_grants", seen, 5);
      for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), order[k], k % 4);
      repeat (6) @(negedge clk);

      add(0, AL, 0, 8, 0, 1, 0, 0, 0, "alloc8");
      add(0, AL, 0, 4, 0, 1, 1, 0, 0, "alloc4");
      add(0, AL, 0, 3, 1, 0, 0, 0, 0, "alloc3");
      add(0, AL, 0, 0, 1, 0, 0, 0, 0, "alloc0");
      for (int k = 1; k <= 10; k++)
         add(0, WR, 0, 16'(k), 0, 0, 0, 1, 12'((k-1) % 8), $sformatf("wr%0d", k));
      add(0, RD, 0, 0, 0, 1, 10, 1, 1, "rd_d0");
      add(0, RD, 0, 7, 0, 1, 3, 1, 2, "rd_d7");
      add(0, RD, 0, 8, 1, 0, 0, 0, 0, "rd_d8");
      add(0, WR, 1, 16'hAA, 0, 0, 0, 1, 8, "wr_h1");
      add(0, RD, 1, 0, 0, 1, 16'hAA, 1, 8, "rd_h1");
      add(0, RD, 2, 0, 1, 0, 0, 0, 0, "rd_h2_unalloc");
      add(0, RD, 16'h0020, 0, 1, 0, 0, 0, 0, "rd_upper");
      add(0, WR, 16'h8000, 5, 1, 0, 0, 0, 0, "wr_upper");
      run_vecs();

      inject_err = 1'b1;
      do_req(0, WR, 0, 99, d, e, lat, got);
      check("t4_err", e, 1);
      check("t4_addr", last_addr, 2);
      inject_err = 1'b0;
      do_req(0, WR, 0, 11, d, e, lat, got);
      check("t4_rewrite_err", e, 0);
      check("t4_rewrite_addr", last_addr, 2);
      check("t4_mem", mem[2], 11);
      do_req(0, RD, 0, 0, d, e, lat, got);
      check("t4_rd_d0", d, 11);
      sram_lat = 3;
      do_req(0, RD, 0, 1, d, e, lat, got);
      check("t4_rd_d1", d, 10);
      check("t4_wait_lat", lat, 6);
      sram_lat = 0;

      add(2, FR, 0, 0, 0, 0, 0, 0, 0, "free1");
      add(2, AL, 0, 16'h1000, 0, 1, 0, 0, 0, "alloc_full");
      add(2, AL, 0, 1, 1, 0, 0, 0, 0, "alloc_over");
      add(2, FR, 0, 0, 0, 0, 0, 0, 0, "free2");
      add(2, AL, 0, 1, 0, 1, 0, 0, 0, "alloc_after_free");
      add(1, WR, 0, 16'h55, 0, 0, 0, 1, 0, "sz1_wr_a");
      add(1, WR, 0, 16'h66, 0, 0, 0, 1, 0, "sz1_wr_b");
      add(1, RD, 0, 0, 0, 1, 16'h66, 1, 0, "sz1_rd_d0");
      add(1, RD, 0, 1, 1, 0, 0, 0, 0, "sz1_rd_d1");
      add(3, FR, 0, 0, 0, 0, 0, 0, 0, "free3");
      for (int k = 0; k < NB; k++)
         add(3, AL, 0, 1, 0, 1, 16'(k), 0, 0, $sformatf("alloc_h%0d", k));
      add(3, AL, 0, 1, 1, 0, 0, 0, 0, "alloc_nbufs");
      add(3, WR, 31, 16'h31, 0, 0, 0, 1, 31, "wr_h31");
      add(3, RD, 31, 0, 0, 1, 16'h31, 1, 31, "rd_h31");
      run_vecs();

      // Reset lands while the SRAM is still busy with a write.
      sram_lat = 20;
      launch(0, WR, 31, 16'h77, ok);
      check("t6_accept", ok, 1);
      req_seen = 1'b0;
      for (int i = 0; i < 10 && !req_seen; i++) begin
         if (sram_req) req_seen = 1'b1;
         else @(negedge clk);
      end
      check("t6_req_seen", req_seen, 1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_sram_req", sram_req, 0);
      check("t6_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      hits = 0;
      repeat (25) begin
         @(negedge clk);
         if (rsp_valid != '0) hits++;
      end
      check("t6_no_rsp", hits, 0);
      sram_lat = 0;
      check("t6_mem_kept", mem[31], 16'h31);
      do_req(0, RD, 31, 0, d, e, lat, got);
      check("t6_stale_handle_err", e, 1);
      check("t6_stale_handle_lat", lat, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
